// File: rtl/cross_bar_slave_mem.sv
// Word-addressed memory target for a crossbar master port: single-beat req/ack transfers,
// programmable ack wait states and in-order read responses after a fixed pipeline latency.
module cross_bar_slave_mem #(
    parameter int AWIDTH      = 32,
    parameter int DWIDTH      = 32,
    parameter int MEM_DEPTH   = 256,
    parameter int RD_LATENCY  = 2,
    parameter int WAIT_CYCLES = 0
) (
    input  logic              aclk_i,
    input  logic              aresetn_i,
    input  logic              req_i,
    input  logic [AWIDTH-1:0] addr_i,
    input  logic              cmd_i,
    input  logic [DWIDTH-1:0] wdata_i,
    output logic              ack_o,
    output logic [DWIDTH-1:0] rdata_o,
    output logic              resp_o
);

    localparam int         BYTE_LSB = $clog2(DWIDTH / 8);
    localparam int         IDX_W    = $clog2(MEM_DEPTH);
    localparam logic [3:0] WAIT_CNT = 4'(WAIT_CYCLES);

    typedef enum logic {
        ST_IDLE,
        ST_WAIT
    } state_e;

    state_e                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic                    ack_w;
    logic                    wr_fire;
    logic                    rd_fire;
    logic [IDX_W-1:0]        idx;
    logic [DWIDTH-1:0]       mem [MEM_DEPTH];
    logic [DWIDTH-1:0]       rd_word_q;
    logic [DWIDTH-1:0]       out_data;
    logic [RD_LATENCY-1:0]   vld_q, vld_d;
    logic                    primed_q;
    logic                    unused_addr;

    // Upper address bits alias onto the same words.
    assign idx         = addr_i[BYTE_LSB +: IDX_W];
    assign unused_addr = ^addr_i;

    always_comb begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
        ack_w   = 1'b0;
        if (req_i && aresetn_i) begin
            ack_w = ((state_q == ST_IDLE) && (WAIT_CNT == 4'd0)) ||
                    ((state_q == ST_WAIT) && (cnt_q == WAIT_CNT));
            if (!ack_w) begin
                cnt_d   = cnt_q + 4'd1;
                state_d = ST_WAIT;
            end
        end
    end

    assign ack_o   = ack_w;
    assign wr_fire = req_i & ack_w & cmd_i;
    assign rd_fire = req_i & ack_w & ~cmd_i;
    assign vld_d   = RD_LATENCY'({vld_q, rd_fire});

    always_ff @(posedge aclk_i or negedge aresetn_i) begin
        if (!aresetn_i) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 4'd0;
            vld_q    <= '0;
            primed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            vld_q   <= vld_d;
            if (vld_q[RD_LATENCY-1]) begin
                primed_q <= 1'b1;
            end
        end
    end

    // Memory contents survive reset, so the array and its read register stay reset-free.
    always_ff @(posedge aclk_i) begin
        if (wr_fire) begin
            mem[idx] <= wdata_i;
        end
        if (rd_fire) begin
            rd_word_q <= mem[idx];
        end
    end

    generate
        if (RD_LATENCY == 1) begin : g_lat1
            assign out_data = rd_word_q;
        end else begin : g_latn
            logic [DWIDTH-1:0] stage_q [1:RD_LATENCY-1];

            // Stages only advance behind a valid entry, so the last stage holds its value.
            always_ff @(posedge aclk_i) begin
                if (vld_q[0]) begin
                    stage_q[1] <= rd_word_q;
                end
            end

            for (genvar gi = 2; gi < RD_LATENCY; gi++) begin : g_stage
                always_ff @(posedge aclk_i) begin
                    if (vld_q[gi-1]) begin
                        stage_q[gi] <= stage_q[gi-1];
                    end
                end
            end

            assign out_data = stage_q[RD_LATENCY-1];
        end
    endgenerate

    // rdata reads as zero until the first response after reset.
    assign resp_o  = vld_q[RD_LATENCY-1];
    assign rdata_o = (primed_q || resp_o) ? out_data : '0;

endmodule
